spi_slave_fifo: RTL

//  Parametrised SPI slave: all four SPI modes, DATA_W-bit words, multi-word frames per SSEL assertion.

---
 rtl/spi_slave_pkg.sv | 22 ++
 rtl/spi_rx_fifo.sv | 48 ++++
 rtl/spi_slave_fifo.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared SPI slave types and helpers.
// Used by spi_slave_fifo and spi_rx_fifo.
package spi_slave_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // CPOL==CPHA means the sampling edge is the rising one.
    function automatic logic sample_on_rise(
        input logic cpol,
        input logic cpha
    );
        return cpol == cpha;
    endfunction

    function automatic int bitcnt_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: first-word-fallthrough synchronous FIFO.
// Push on full is accepted when a pop happens in the same clock.
module spi_rx_fifo
    import spi_slave_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q;
    logic [AW:0]       rptr_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: SPI slave, all modes, TX holding reg, RX FIFO.
// Optional word counter port under `SPI_SLAVE_WORD_CNT_EN.
module spi_slave_fifo
    import spi_slave_pkg::*;
#(
    parameter int              DATA_W   = 8,
    parameter bit              CPOL     = 1'b0,
    parameter bit              CPHA     = 1'b0,
    parameter int              RX_DEPTH = 4,
    parameter logic [DATA_W-1:0] TX_IDLE = '1,
    parameter int              SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              mosi,
    input  logic              ssel_n,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              tx_underrun,
    output logic              rx_overrun,
    output logic              frame_err,
    output logic              busy
`ifdef SPI_SLAVE_WORD_CNT_EN
    ,
    output logic [7:0]        word_cnt
`endif
);

    localparam int BITCNT_W = bitcnt_w(DATA_W);
    localparam spi_mode_t MODE = spi_mode_t'{CPOL, CPHA};
    localparam bit RISE = sample_on_rise(MODE.cpol, MODE.cpha);
    localparam logic [BITCNT_W-1:0] LAST = BITCNT_W'(DATA_W - 1);

    logic [SYNC_STG-1:0] sck_sync_q;
    logic [SYNC_STG-1:0] mosi_sync_q;
    logic [SYNC_STG-1:0] ssel_sync_q;
    logic                sck_prev_q;
    logic                busy_prev_q;

    logic sck_s, mosi_s, busy_s;
    logic sck_rise, sck_fall;
    logic sample_ev, shift_ev;
    logic start_ev, rel_ev;
    logic word_end, load_ev;

    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [DATA_W-2:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   push_word_q, push_word_d;
    logic                push_q, push_d;
    logic [DATA_W-1:0]   shifter_q, shifter_d;
    logic                skip_q, skip_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                underrun_q, underrun_d;
    logic                overrun_q, overrun_d;
    logic                frame_err_q, frame_err_d;

    logic fifo_full, fifo_empty, fifo_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q  <= {SYNC_STG{CPOL}};
            mosi_sync_q <= '0;
            ssel_sync_q <= '1;
            sck_prev_q  <= CPOL;
            busy_prev_q <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STG-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STG-2:0], mosi};
            ssel_sync_q <= {ssel_sync_q[SYNC_STG-2:0], ssel_n};
            sck_prev_q  <= sck_s;
            busy_prev_q <= busy_s;
        end
    end

    assign sck_s  = sck_sync_q[SYNC_STG-1];
    assign mosi_s = mosi_sync_q[SYNC_STG-1];
    assign busy_s = ~ssel_sync_q[SYNC_STG-1];

    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign sample_ev = busy_s & (RISE ? sck_rise : sck_fall);
    assign shift_ev  = busy_s & (RISE ? sck_fall : sck_rise);
    assign start_ev  = busy_s & ~busy_prev_q;
    assign rel_ev    = ~busy_s & busy_prev_q;
    assign word_end  = sample_ev && (bitcnt_q == LAST);
    assign load_ev   = CPHA ? (shift_ev && (bitcnt_q == '0))
                            : (start_ev || word_end);

    always_comb begin
        bitcnt_d    = bitcnt_q;
        rx_shift_d  = rx_shift_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        shifter_d   = shifter_q;
        skip_d      = skip_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        if (rel_ev) begin
            bitcnt_d    = '0;
            rx_shift_d  = '0;
            shifter_d   = '0;
            skip_d      = 1'b0;
            frame_err_d = (bitcnt_q != '0);
        end else begin
            if (sample_ev) begin
                rx_shift_d = {rx_shift_q[DATA_W-3:0], mosi_s};
                bitcnt_d   = word_end ? '0
                                      : bitcnt_q + BITCNT_W'(1);
                if (word_end) begin
                    push_d      = 1'b1;
                    push_word_d = {rx_shift_q, mosi_s};
                end
            end
            if (load_ev) begin
                if (hold_full_q) begin
                    shifter_d   = hold_q;
                    hold_full_d = 1'b0;
                end else begin
                    shifter_d  = TX_IDLE;
                    underrun_d = 1'b1;
                end
                // A CPHA=0 word-end load must survive the next shift edge.
                skip_d = !CPHA && word_end;
            end else if (shift_ev) begin
                if (skip_q) skip_d = 1'b0;
                else        shifter_d = shifter_q << 1;
            end
        end
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    assign fifo_pop  = rx_ready && !fifo_empty;
    assign overrun_d = push_q && fifo_full && !fifo_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitcnt_q    <= '0;
            rx_shift_q  <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            shifter_q   <= '0;
            skip_q      <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bitcnt_q    <= bitcnt_d;
            rx_shift_q  <= rx_shift_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
            shifter_q   <= shifter_d;
            skip_q      <= skip_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    spi_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .wdata (push_word_q),
        .pop   (fifo_pop),
        .rdata (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign miso        = busy_s ? shifter_q[DATA_W-1] : 1'b0;
    assign busy        = busy_s;
    assign tx_ready    = ~hold_full_q;
    assign rx_valid    = ~fifo_empty;
    assign tx_underrun = underrun_q;
    assign rx_overrun  = overrun_q;
    assign frame_err   = frame_err_q;

`ifdef SPI_SLAVE_WORD_CNT_EN
    logic [7:0] word_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt_q <= '0;
        end else if (start_ev) begin
            word_cnt_q <= '0;
        end else if (word_end && word_cnt_q != 8'hFF) begin
            word_cnt_q <= word_cnt_q + 8'd1;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule
